// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared constants for the serial pattern matcher
//
// Purpose: FSM state encoding and reset-time configuration defaults.
// Ports:   none (package).
package pattern_pkg;

  // Matcher state: FILL until enough bits have been seen to form a full
  // window, ARMED once the next accepted bit can complete a match.
  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  // Out of reset the block looks for overlapping "11".
  localparam logic [31:0] DEF_PATTERN = 32'h0000_0003;
  localparam int          DEF_LEN     = 2;
  localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses, holding at all-ones instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset (count -> 0)
//   inc    - increment request
//   clr    - synchronous clear; clr together with inc yields 1
//   count  - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      // The event arriving in the clearing cycle is still counted.
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_matcher.sv
// rtl/pattern_matcher.sv - configurable serial bit-pattern detector
//
// Purpose: shifts in a serial bit stream and pulses detected whenever the
//          most recent cfg_len bits equal the configured pattern, with
//          overlapping or non-overlapping match semantics.
// Ports:
//   clk, reset     - clock (rising edge) and asynchronous active-high reset
//   in_valid       - in_bit is accepted this cycle
//   in_bit         - serial data bit
//   cfg_load       - strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern    - pattern, bit cfg_len-1 received first, bit 0 last
//   cfg_len        - active pattern length (2..PAT_W)
//   cfg_overlap    - 1 = overlapping matches, 0 = non-overlapping
//   count_clr      - synchronous clear of match_count
//   detected       - one-cycle pulse per match, registered
//   match_count    - saturating match count
//   cfg_err        - one-cycle pulse after a rejected cfg_load
module pattern_matcher
  import pattern_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             ovl_q, ovl_d;
  logic             det_q, det_d;
  logic             err_q, err_d;

  logic [0:0]       state;
  logic             cfg_ok;
  logic             accept;
  logic             match;
  logic [PAT_W:0]   window;
  logic [PAT_W:0]   mask;

  // History with the incoming bit appended; the low len bits are the
  // candidate window. The mask top bit is always 0 because len <= PAT_W.
  assign window = {hist_q, in_bit};
  assign mask   = ~({(PAT_W + 1){1'b1}} << len_q);

  // ARMED once len-1 bits are already held, so the next bit can complete.
  assign state  = (({1'b0, fill_q} + (LEN_W + 1)'(1)) < {1'b0, len_q}) ? ST_FILL : ST_ARMED;

  assign cfg_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_W));

  // A configuration strobe wins over data; the coincident bit is dropped.
  assign accept = in_valid && !cfg_load;

  assign match  = accept && (state == ST_ARMED) &&
                  (((window ^ {1'b0, pat_q}) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    len_d  = len_q;
    fill_d = fill_q;
    ovl_d  = ovl_q;
    det_d  = match;
    err_d  = cfg_load && !cfg_ok;

    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end
    end else if (accept) begin
      hist_d = window[PAT_W-1:0];
      if (match && !ovl_q) begin
        // Non-overlapping: the completing bit must not seed the next match.
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      pat_q  <= PAT_W'(DEF_PATTERN);
      len_q  <= LEN_W'(DEF_LEN);
      fill_q <= '0;
      ovl_q  <= DEF_OVERLAP;
      det_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
      err_q  <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr),
    .count (match_count)
  );

  assign detected = det_q;
  assign cfg_err  = err_q;

endmodule
